// File: rtl/tpumac_pkg.sv
// Shared definitions for the tpumac systolic row: default geometry and
// signed saturation limits used by every MAC cell.
package tpumac_pkg;

  localparam int unsigned DEF_BITS_AB = 8;
  localparam int unsigned DEF_BITS_C  = 16;
  localparam int unsigned DEF_COLS    = 4;

  function automatic logic signed [63:0] sat_max(input int unsigned bits);
    return (64'sd1 <<< (bits - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int unsigned bits);
    return -(64'sd1 <<< (bits - 1));
  endfunction

endpackage

// File: rtl/tpumac_sat_cell.sv
// One systolic MAC cell: A/B operand registers, accumulator with optional
// saturation, and a sticky overflow flag.
module tpumac_sat_cell
  import tpumac_pkg::*;
#(
  parameter int unsigned BITS_AB = DEF_BITS_AB,
  parameter int unsigned BITS_C  = DEF_BITS_C
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      wr_en,
  input  logic                      clr,
  input  logic                      sat_en,
  input  logic signed [BITS_AB-1:0] a_in,
  input  logic signed [BITS_AB-1:0] b_in,
  input  logic signed [BITS_C-1:0]  c_in,
  output logic signed [BITS_AB-1:0] a,
  output logic signed [BITS_AB-1:0] b,
  output logic signed [BITS_C-1:0]  c,
  output logic                      ovf
);

  localparam logic signed [BITS_C-1:0] C_MAX = BITS_C'(sat_max(BITS_C));
  localparam logic signed [BITS_C-1:0] C_MIN = BITS_C'(sat_min(BITS_C));
  localparam int unsigned PW = 2 * BITS_AB;

  logic signed [PW-1:0]     prod;
  logic        [BITS_C:0]   sum;
  logic                     ovf_now;
  logic signed [BITS_C-1:0] res;

  // One guard bit above the accumulator: overflow iff the top two bits differ.
  always_comb begin
    prod    = a_in * b_in;
    sum     = {{(BITS_C + 1 - PW){prod[PW-1]}}, prod} + {c[BITS_C-1], c};
    ovf_now = sum[BITS_C] ^ sum[BITS_C-1];
    res     = sum[BITS_C-1:0];
    if (ovf_now && sat_en) begin
      res = sum[BITS_C] ? C_MIN : C_MAX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a   <= '0;
      b   <= '0;
      c   <= '0;
      ovf <= 1'b0;
    end else begin
      if (en) begin
        a <= a_in;
        b <= b_in;
      end
      if (clr) begin
        c   <= '0;
        ovf <= 1'b0;
      end else if (en) begin
        if (wr_en) begin
          c   <= c_in;
          ovf <= 1'b0;
        end else begin
          c   <= res;
          ovf <= ovf | ovf_now;
        end
      end
    end
  end

endmodule

// File: rtl/tpumac_row.sv
// One-dimensional systolic MAC row: COLS cells sharing an A stream that is
// registered cell to cell, each with its own B operand and accumulator.
module tpumac_row
  import tpumac_pkg::*;
#(
  parameter int unsigned BITS_AB = DEF_BITS_AB,
  parameter int unsigned BITS_C  = DEF_BITS_C,
  parameter int unsigned COLS    = DEF_COLS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic                           WrEn,
  input  logic                           clr,
  input  logic                           sat_en,
  input  logic signed [BITS_AB-1:0]      Ain,
  input  logic [COLS-1:0][BITS_AB-1:0]   Bin,
  input  logic [COLS-1:0][BITS_C-1:0]    Cin,
  output logic signed [BITS_AB-1:0]      Aout,
  output logic [COLS-1:0][BITS_AB-1:0]   Bout,
  output logic [COLS-1:0][BITS_C-1:0]    Cout,
  output logic [COLS-1:0]                ovf
);

  if (BITS_C < 2 * BITS_AB) begin : g_bad_bits_c
    $error("tpumac_row: BITS_C must be >= 2*BITS_AB");
  end
  if (COLS < 1) begin : g_bad_cols
    $error("tpumac_row: COLS must be >= 1");
  end

  logic [COLS-1:0][BITS_AB-1:0] a_reg;
  logic [COLS-1:0][BITS_AB-1:0] a_feed;

  for (genvar k = 0; k < COLS; k++) begin : g_cell
    if (k == 0) begin : g_head
      assign a_feed[k] = Ain;
    end else begin : g_chain
      assign a_feed[k] = a_reg[k-1];
    end

    tpumac_sat_cell #(
      .BITS_AB (BITS_AB),
      .BITS_C  (BITS_C)
    ) u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .wr_en  (WrEn),
      .clr    (clr),
      .sat_en (sat_en),
      .a_in   (a_feed[k]),
      .b_in   (Bin[k]),
      .c_in   (Cin[k]),
      .a      (a_reg[k]),
      .b      (Bout[k]),
      .c      (Cout[k]),
      .ovf    (ovf[k])
    );
  end

  assign Aout = a_reg[COLS-1];

endmodule
